// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-channel time-division demultiplexer.
//
// De-interleaves a serial sample stream (one channel per accepted beat,
// channel 0 flagged by sync) into four registered parallel outputs. The
// outputs only ever move together on frame completion, so consumers never
// see a mix of two frames.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         serial sample, belongs to channel sel when accepted
//   din_valid   sample present; accepted on a rising edge
//   sync        accepted sample is channel 0 (frame start)
//   y0..y3      registered channel outputs
//   sel         channel index the next accepted sample is stored as
//   frame_valid one-cycle pulse: y0..y3 just loaded with a full frame
//   locked      high while in RUN
//   sync_err    one-cycle pulse on a framing violation

// Per-channel output register with load enable.
module tdm_demux4_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_o <= '0;
    else if (ld_i) q_o <= d_i;
  end
endmodule

module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);
  localparam int NUM_CH = 4;

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [2:0][WIDTH-1:0]   h_q, h_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;
  logic                    ld_y;

  // Lane inputs: channels 0..2 come from the holding registers, channel 3
  // is the sample completing the frame, taken straight from din.
  logic [NUM_CH-1:0][WIDTH-1:0] lane_d;
  logic [NUM_CH-1:0][WIDTH-1:0] lane_q;

  assign lane_d = {din, h_q[2], h_q[1], h_q[0]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tdm_demux4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (ld_y),
      .d_i   (lane_d[i]),
      .q_o   (lane_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sel_q   <= 2'd0;
      h_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      h_q     <= h_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    h_d     = h_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    ld_y    = 1'b0;
    if (din_valid) begin
      if (sync) begin
        // Frame start always restarts at channel 0; if we were mid-frame
        // the partial frame is dropped and flagged.
        h_d[0]  = din;
        sel_d   = 2'd1;
        state_d = RUN;
        if (state_q == RUN && sel_q != 2'd0) err_d = 1'b1;
      end else if (state_q == RUN) begin
        case (sel_q)
          2'd0: begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
          2'd1: begin
            h_d[1] = din;
            sel_d  = 2'd2;
          end
          2'd2: begin
            h_d[2] = din;
            sel_d  = 2'd3;
          end
          default: begin
            ld_y  = 1'b1;
            fv_d  = 1'b1;
            sel_d = 2'd0;
          end
        endcase
      end
      // HUNT with sync=0: sample discarded, nothing changes.
    end
  end

  assign y0          = lane_q[0];
  assign y1          = lane_q[1];
  assign y2          = lane_q[2];
  assign y3          = lane_q[3];
  assign sel         = sel_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk, rst_n;
  logic [W-1:0] din;
  logic         din_valid, sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic [1:0]   sel;
  logic         frame_valid, locked, sync_err;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .sel(sel),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int n_push = 0;

  logic [3:0][W-1:0] sb_q[$];
  logic [3:0][W-1:0] ycur;   // last frame the outputs must hold

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][W-1:0] ycat();
    return {y3, y2, y1, y0};
  endfunction

  // Monitor: every frame_valid pulse pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: frame 0x%0h with empty scoreboard", ycat());
      end else begin
        logic [3:0][W-1:0] e;
        e = sb_q.pop_front();
        n_pop++;
        chk("sb_frame", int'(ycat()), int'(e));
      end
    end
  end

  // One cycle: drive at negedge, rising edge, check at next negedge.
  // When efv is set the frame f is pushed to the scoreboard first.
  task automatic beat(input logic v, input logic s, input logic [W-1:0] d,
                      input int esel, input int elock, input int eerr,
                      input int efv, input logic [3:0][W-1:0] f);
    din_valid = v; sync = s; din = d;
    if (efv != 0) begin
      sb_q.push_back(f);
      n_push++;
    end
    @(posedge clk);
    @(negedge clk);
    if (efv != 0) ycur = f;
    chk("sel", int'(sel), esel);
    chk("locked", int'(locked), elock);
    chk("sync_err", int'(sync_err), eerr);
    chk("frame_valid", int'(frame_valid), efv);
    chk("y_hold", int'(ycat()), int'(ycur));
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int esel, input int elock);
    beat(1'b0, 1'b0, 4'hF, esel, elock, 0, 0, '0);
  endtask

  // Full frame a,b,c,d with sync on a, lock expected from the first beat.
  task automatic frame(input logic [W-1:0] a, b, c, d);
    beat(1'b1, 1'b1, a, 1, 1, 0, 0, '0);
    beat(1'b1, 1'b0, b, 2, 1, 0, 0, '0);
    beat(1'b1, 1'b0, c, 3, 1, 0, 0, '0);
    beat(1'b1, 1'b0, d, 0, 1, 0, 1, {d, c, b, a});
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sync = 1'b0; ycur = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_err", int'(sync_err), 0);
    chk("rst_y", int'(ycat()), 0);
    rst_n = 1'b1;

    // HUNT: idle and non-sync beats are ignored without error
    idle(0, 0);
    beat(1'b1, 1'b0, 4'h5, 0, 0, 0, 0, '0);

    // Reset then lock
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    idle(0, 1);

    // Gapped input: sel holds at 2 across the gap
    beat(1'b1, 1'b1, 4'h5, 1, 1, 0, 0, '0);
    beat(1'b1, 1'b0, 4'h6, 2, 1, 0, 0, '0);
    idle(2, 1); idle(2, 1); idle(2, 1);
    beat(1'b1, 1'b0, 4'h7, 3, 1, 0, 0, '0);
    beat(1'b1, 1'b0, 4'h8, 0, 1, 0, 1, {4'h8, 4'h7, 4'h6, 4'h5});

    // Missing sync at sel=0: error, unlock, y held
    beat(1'b1, 1'b0, 4'h9, 0, 0, 1, 0, '0);
    idle(0, 0);
    // Relock, then early sync at sel=2
    beat(1'b1, 1'b1, 4'h1, 1, 1, 0, 0, '0);
    beat(1'b1, 1'b0, 4'h2, 2, 1, 0, 0, '0);
    beat(1'b1, 1'b1, 4'hE, 1, 1, 1, 0, '0);
    beat(1'b1, 1'b0, 4'hD, 2, 1, 0, 0, '0);
    beat(1'b1, 1'b0, 4'hC, 3, 1, 0, 0, '0);
    beat(1'b1, 1'b0, 4'hB, 0, 1, 0, 1, {4'hB, 4'hC, 4'hD, 4'hE});

    // Reset mid-frame at sel=2, asserted between edges
    beat(1'b1, 1'b1, 4'h3, 1, 1, 0, 0, '0);
    beat(1'b1, 1'b0, 4'h4, 2, 1, 0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_y", int'(ycat()), 0);
    chk("mid_rst_err", int'(sync_err), 0);
    ycur = '0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b1, 1'b0, 4'h5, 0, 0, 0, 0, '0);
    beat(1'b1, 1'b0, 4'h6, 0, 0, 0, 0, '0);

    // Back-to-back frames, no gaps
    frame(4'h1, 4'h2, 4'h3, 4'h4);
    frame(4'h9, 4'hA, 4'h5, 4'h6);
    frame(4'hF, 4'h0, 4'h7, 4'hC);
    idle(0, 1);

    chk("sb_empty", sb_q.size(), 0);
    chk("sb_pops", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
